btb_ras_predictor: RTL and testbench
====================================

# btb_ras_predictor

Parametrised successor to the current direct-mapped BTB lookup path: a set-associative branch target buffer with pseudo-LRU replacement plus a return address stack (RAS) for predicting `jalr` returns. Returns currently always flush at resolve. Sits beside the fetch stage: combinational lookup on the IF PC, training from the resolved control transfer in MEM, and repair on pipeline redirect.

## Interface
Parameters:
- `SETS`, 32: BTB sets; power of two, ≥2.
- `WAYS`, 2: associativity; power of two, 1..8.
- `RAS_DEPTH`, 8: RAS entries; power of two, ≥2.

Ports (clock and reset first):
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `load` in 1: advance enable (driven `~cache_stall`); gates every state update.
- `if_pc` in 32: fetch PC.
- `if_opcode` in 7: fetched opcode.
- `if_rd` in 5: fetched rd.
- `if_rs1` in 5: fetched rs1.
- `pred_hit` out 1: redirect fetch to `pred_target`.
- `pred_target` out 32: predicted target.
- `pred_is_ret` out 1: prediction sourced from RAS.
- `upd_valid` in 1: MEM-stage resolved control transfer present.
- `upd_pc` in 32: resolved PC.
- `upd_opcode` in 7: resolved opcode.
- `upd_rd` in 5: resolved rd.
- `upd_rs1` in 5: resolved rs1.
- `upd_target` in 32: resolved target, bit 0 already cleared.
- `flush` in 1: redirect (mispredict or jalr flush) this cycle.

## Operation
- Index = `pc[2 +: log2(SETS)]`; tag = remaining upper bits.
- Entry: valid, tag, target.
- Link registers are x1 and x5.
- Call: `jal`/`jalr` with rd ∈ link.
- Return: `jalr` with rd = x0 and rs1 ∈ link.
- Call+return: `jalr`, rd and rs1 both link, rd ≠ rs1. Replaces top of stack: pop then push, count unchanged.
- Lookup: comb; BTB hit = any way valid and tag equal, lowest way wins on duplicates.
- `pred_is_ret` = IF return and speculative RAS non-empty.
- `pred_hit` = `pred_is_ret`, or BTB hit on `op_br`/`op_jal`/`op_jalr`.
- `pred_target` = RAS top if `pred_is_ret`, else hit way's target, else 0.
- Conditional taken/not-taken stays with the perceptron; this block supplies the target only.
- Speculative RAS: on `load`, IF call pushes `if_pc+4`; IF return pops.
- Committed RAS: on `load && upd_valid`, same rules using `upd_*`, pushing `upd_pc+4`.
- `load && flush`: speculative RAS (entries, ptr, count) is copied from committed RAS after the committed update of that cycle. Flush overrides any IF push/pop in that cycle.
- RAS full push: overwrite oldest slot (ptr wraps), count saturates at `RAS_DEPTH`.
- RAS empty pop: no change; return falls back to the BTB.
- BTB update on `load && upd_valid` for br/jal/jalr, returns excluded:
  - tag hit: rewrite target;
  - else fill the lowest invalid way;
  - else replace the tree-PLRU victim.
- PLRU touch: written way marked MRU. Lookups do not touch PLRU.
- `WAYS=1`: no PLRU state.

## Timing
- Lookup latency 0 cycles (comb from `if_*`); updates visible the cycle after the edge.
- Same-cycle update and lookup to the same set: lookup sees the pre-update contents.
- `load=0`: all state frozen, including flush.
- Reset (async):
  - all valid bits 0, PLRU 0;
  - both RAS ptr=0, count=0;
  - outputs `pred_hit`=0, `pred_is_ret`=0, `pred_target`=0.
- Reset mid-operation discards pending updates; first edge after deassertion behaves as a fresh start.

## Structure
- Package `bpu_types`:
  - `btb_entry_t` struct;
  - link-register constants;
  - functions `is_call(opcode,rd)` and `is_ret(opcode,rd,rs1)`;
  - PLRU index helper.
- Sub-module `ras_stack`: circular stack with push/pop/replace, snapshot-out, and restore-in ports. Instantiated twice (speculative, committed).
- BTB arrays and PLRU are flops inside the top; no SRAM macro.

## Test plan
- BTB fill and hit: reset; update `jal` pc 0x100 → 0x200; next cycle `if_pc`=0x100 with `op_jal` → `pred_hit`=1, target 0x200. Same lookup before the update edge → `pred_hit`=0.
- Conflict and PLRU, `SETS`=32, `WAYS`=2: train pcs 0x100, 0x180, 0x200 (same index, 0x80 apart).
  - 0x100 evicted, 0x180 and 0x200 hit;
  - retouch 0x180, then train 0x280 → 0x200 evicted.
- Call/return: IF `jal x1` at 0x400 then IF `jalr x0,0(x1)` → `pred_is_ret`=1, target 0x404. A second return on the empty RAS → BTB fallback, `pred_hit`=0 if untrained.
- RAS overflow, `RAS_DEPTH`=8: 9 calls at pcs 0x1000+16k; 9 returns.
  - targets 0x1084, 0x1074, …, 0x1014;
  - 9th return finds the RAS empty (oldest entry overwritten) → `pred_is_ret`=0.
- Flush repair: committed RAS holds 0x504; speculatively push 0x604, 0x704; assert `flush` → next IF return predicts 0x504.
- Stall and reset: `load`=0 with `upd_valid`/`flush` high → no state change. Assert `rst` mid-run → outputs 0 immediately; all prior entries miss.

Source files
------------

// File: rtl/bpu_types.sv
// Shared types and decode helpers for the BTB/RAS branch target predictor.
// Opcode and link-register constants, BTB entry layout, RAS operations, tree-PLRU helpers.
package bpu_types;

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [4:0] LINK_RA = 5'd1;
  localparam logic [4:0] LINK_T0 = 5'd5;
  localparam int unsigned PLRU_W = 7;

  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
  } btb_entry_t;

  typedef enum logic [1:0] {
    RAS_NONE,
    RAS_PUSH,
    RAS_POP,
    RAS_REPL
  } ras_op_t;

  function automatic logic is_link(input logic [4:0] r);
    return (r == LINK_RA) || (r == LINK_T0);
  endfunction

  function automatic logic is_cti(input logic [6:0] opcode);
    return (opcode == OP_BR) || (opcode == OP_JAL) || (opcode == OP_JALR);
  endfunction

  function automatic logic is_call(input logic [6:0] opcode, input logic [4:0] rd);
    return ((opcode == OP_JAL) || (opcode == OP_JALR)) && is_link(rd);
  endfunction

  function automatic logic is_ret(input logic [6:0] opcode, input logic [4:0] rd,
                                  input logic [4:0] rs1);
    return (opcode == OP_JALR) && (rd == 5'd0) && is_link(rs1);
  endfunction

  // Coroutine-style jalr (both link, different) swaps the top of stack.
  function automatic ras_op_t ras_op(input logic [6:0] opcode, input logic [4:0] rd,
                                     input logic [4:0] rs1);
    if ((opcode == OP_JALR) && is_link(rd) && is_link(rs1) && (rd != rs1)) return RAS_REPL;
    if (is_call(opcode, rd)) return RAS_PUSH;
    if (is_ret(opcode, rd, rs1)) return RAS_POP;
    return RAS_NONE;
  endfunction

  // Node bit 0 points the victim to the lower half, 1 to the upper half.
  function automatic logic [2:0] plru_victim(input logic [PLRU_W-1:0] tree,
                                             input int unsigned lvls);
    logic [2:0]  way;
    int unsigned node;
    logic        dir;
    way  = '0;
    node = 0;
    for (int unsigned l = 0; l < 3; l++) begin
      if (l < lvls) begin
        dir  = tree[node[2:0]];
        way  = {way[1:0], dir};
        node = 2 * node + 1 + 32'(dir);
      end
    end
    return way;
  endfunction

  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] tree,
                                                   input logic [2:0] way,
                                                   input int unsigned lvls);
    logic [PLRU_W-1:0] t;
    int unsigned       node;
    logic              dir;
    t    = tree;
    node = 0;
    for (int unsigned l = 0; l < 3; l++) begin
      if (l < lvls) begin
        dir            = way[lvls-1-l];
        t[node[2:0]]   = ~dir;
        node           = 2 * node + 1 + 32'(dir);
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return address stack with push/pop/replace and whole-state restore.
// snap_* expose next-state so a sibling stack can copy it in the same cycle.
module ras_stack
  import bpu_types::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  ras_op_t                 op_i,
  input  logic [31:0]             push_addr_i,
  input  logic                    restore_i,
  input  logic [DEPTH-1:0][31:0]  restore_entries_i,
  input  logic [PTR_W-1:0]        restore_ptr_i,
  input  logic [CNT_W-1:0]        restore_count_i,
  output logic [DEPTH-1:0][31:0]  snap_entries_o,
  output logic [PTR_W-1:0]        snap_ptr_o,
  output logic [CNT_W-1:0]        snap_count_o,
  output logic [31:0]             top_o,
  output logic                    empty_o
);

  logic [DEPTH-1:0][31:0] entries_q, entries_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d, top_idx;
  logic [CNT_W-1:0]       count_q, count_d;

  assign top_idx = ptr_q - PTR_W'(1);
  assign top_o   = entries_q[top_idx];
  assign empty_o = (count_q == '0);

  always_comb begin
    entries_d = entries_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    if (restore_i) begin
      entries_d = restore_entries_i;
      ptr_d     = restore_ptr_i;
      count_d   = restore_count_i;
    end else begin
      case (op_i)
        RAS_POP: begin
          if (count_q != '0) begin
            ptr_d   = top_idx;
            count_d = count_q - CNT_W'(1);
          end
        end
        RAS_PUSH, RAS_REPL: begin
          // Replace on an empty stack degenerates to a plain push.
          if ((op_i == RAS_REPL) && (count_q != '0)) begin
            entries_d[top_idx] = push_addr_i;
          end else begin
            entries_d[ptr_q] = push_addr_i;
            ptr_d            = ptr_q + PTR_W'(1);
            if (count_q != CNT_W'(DEPTH)) count_d = count_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries_q <= '0;
      ptr_q     <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
    end
  end

  assign snap_entries_o = entries_d;
  assign snap_ptr_o     = ptr_d;
  assign snap_count_o   = count_d;

endmodule

// File: rtl/btb_ras_predictor.sv
// Set-associative BTB with tree-PLRU replacement plus speculative/committed RAS pair.
// Combinational lookup on the IF PC; training from MEM; flush repairs the speculative RAS.
module btb_ras_predictor
  import bpu_types::*;
#(
  parameter int SETS      = 32,
  parameter int WAYS      = 2,
  parameter int RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] if_pc,
  input  logic [6:0]  if_opcode,
  input  logic [4:0]  if_rd,
  input  logic [4:0]  if_rs1,
  output logic        pred_hit,
  output logic [31:0] pred_target,
  output logic        pred_is_ret,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [6:0]  upd_opcode,
  input  logic [4:0]  upd_rd,
  input  logic [4:0]  upd_rs1,
  input  logic [31:0] upd_target,
  input  logic        flush
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int LVLS   = $clog2(WAYS);
  localparam int WAY_W  = (WAYS > 1) ? LVLS : 1;
  localparam int RAS_PW = $clog2(RAS_DEPTH);

  btb_entry_t btb_q [SETS][WAYS];

  logic [IDX_W-1:0] if_idx, upd_idx;
  logic [31:0]      if_tag, upd_tag;
  logic             lk_hit;
  logic [31:0]      lk_target;
  logic             upd_hit, inv_found, btb_wr_en;
  logic [WAY_W-1:0] upd_hit_way, inv_way, victim_way, wr_way;

  assign if_idx  = if_pc[2 +: IDX_W];
  assign if_tag  = if_pc >> (2 + IDX_W);
  assign upd_idx = upd_pc[2 +: IDX_W];
  assign upd_tag = upd_pc >> (2 + IDX_W);

  // Descending scans so the lowest matching way is the one left standing.
  always_comb begin
    lk_hit    = 1'b0;
    lk_target = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (btb_q[if_idx][w].valid && (btb_q[if_idx][w].tag == if_tag)) begin
        lk_hit    = 1'b1;
        lk_target = btb_q[if_idx][w].target;
      end
    end
  end

  always_comb begin
    upd_hit     = 1'b0;
    upd_hit_way = '0;
    inv_found   = 1'b0;
    inv_way     = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (btb_q[upd_idx][w].valid && (btb_q[upd_idx][w].tag == upd_tag)) begin
        upd_hit     = 1'b1;
        upd_hit_way = WAY_W'(w);
      end
      if (!btb_q[upd_idx][w].valid) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign wr_way    = upd_hit ? upd_hit_way : (inv_found ? inv_way : victim_way);
  assign btb_wr_en = load && upd_valid && is_cti(upd_opcode)
                     && !is_ret(upd_opcode, upd_rd, upd_rs1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) btb_q[s][w] <= '0;
      end
    end else if (btb_wr_en) begin
      btb_q[upd_idx][wr_way] <= '{valid: 1'b1, tag: upd_tag, target: upd_target};
    end
  end

  if (WAYS > 1) begin : g_plru
    logic [PLRU_W-1:0] plru_q [SETS];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
      end else if (btb_wr_en) begin
        plru_q[upd_idx] <= plru_touch(plru_q[upd_idx], 3'(wr_way), LVLS);
      end
    end

    assign victim_way = WAY_W'(plru_victim(plru_q[upd_idx], LVLS));
  end else begin : g_no_plru
    assign victim_way = '0;
  end

  ras_op_t                     spec_op, commit_op;
  logic [RAS_DEPTH-1:0][31:0]  commit_snap_entries;
  logic [RAS_PW-1:0]           commit_snap_ptr;
  logic [RAS_PW:0]             commit_snap_count;
  logic [31:0]                 spec_top;
  logic                        spec_empty;

  assign spec_op   = load ? ras_op(if_opcode, if_rd, if_rs1) : RAS_NONE;
  assign commit_op = (load && upd_valid) ? ras_op(upd_opcode, upd_rd, upd_rs1) : RAS_NONE;

  ras_stack #(.DEPTH(RAS_DEPTH)) u_ras_commit (
    .clk              (clk),
    .rst              (rst),
    .op_i             (commit_op),
    .push_addr_i      (upd_pc + 32'd4),
    .restore_i        (1'b0),
    .restore_entries_i('0),
    .restore_ptr_i    ('0),
    .restore_count_i  ('0),
    .snap_entries_o   (commit_snap_entries),
    .snap_ptr_o       (commit_snap_ptr),
    .snap_count_o     (commit_snap_count),
    .top_o            (),
    .empty_o          ()
  );

  // Restore takes the committed stack's post-update state, overriding any IF op.
  ras_stack #(.DEPTH(RAS_DEPTH)) u_ras_spec (
    .clk              (clk),
    .rst              (rst),
    .op_i             (spec_op),
    .push_addr_i      (if_pc + 32'd4),
    .restore_i        (load && flush),
    .restore_entries_i(commit_snap_entries),
    .restore_ptr_i    (commit_snap_ptr),
    .restore_count_i  (commit_snap_count),
    .snap_entries_o   (),
    .snap_ptr_o       (),
    .snap_count_o     (),
    .top_o            (spec_top),
    .empty_o          (spec_empty)
  );

  assign pred_is_ret = is_ret(if_opcode, if_rd, if_rs1) && !spec_empty;
  assign pred_hit    = pred_is_ret || (lk_hit && is_cti(if_opcode));
  assign pred_target = pred_is_ret ? spec_top : (lk_hit ? lk_target : '0);

endmodule

// File: tb/tb_btb_ras_predictor.sv
// Directed scoreboard bench for btb_ras_predictor (SETS=32, WAYS=2, RAS_DEPTH=8).
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_btb_ras_predictor;

  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] if_pc;
  logic [6:0]  if_opcode;
  logic [4:0]  if_rd, if_rs1;
  logic        pred_hit, pred_is_ret;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc, upd_target;
  logic [6:0]  upd_opcode;
  logic [4:0]  upd_rd, upd_rs1;
  logic        flush;

  btb_ras_predictor dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .if_pc      (if_pc),
    .if_opcode  (if_opcode),
    .if_rd      (if_rd),
    .if_rs1     (if_rs1),
    .pred_hit   (pred_hit),
    .pred_target(pred_target),
    .pred_is_ret(pred_is_ret),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_opcode (upd_opcode),
    .upd_rd     (upd_rd),
    .upd_rs1    (upd_rs1),
    .upd_target (upd_target),
    .flush      (flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        eh;
    logic        er;
    logic [31:0] et;
  } exp_t;

  exp_t sb_q[$];
  logic chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: got output with no expected entry");
      end else begin
        e = sb_q.pop_front();
        if (pred_hit !== e.eh || pred_is_ret !== e.er || pred_target !== e.et) begin
          errors++;
          $display("FAIL %s: got hit=%0b ret=%0b target=%08h, expected hit=%0b ret=%0b target=%08h",
                   e.name, pred_hit, pred_is_ret, pred_target, e.eh, e.er, e.et);
        end else begin
          $display("ok   %s: hit=%0b ret=%0b target=%08h", e.name, pred_hit, pred_is_ret,
                   pred_target);
        end
      end
    end
  end

  task automatic set_if(input logic [31:0] pc, input logic [6:0] op,
                        input logic [4:0] rd, input logic [4:0] rs1);
    if_pc = pc; if_opcode = op; if_rd = rd; if_rs1 = rs1;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic [6:0] op,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] tgt);
    upd_valid = v; upd_pc = pc; upd_opcode = op; upd_rd = rd; upd_rs1 = rs1; upd_target = tgt;
  endtask

  task automatic idle();
    load = 1'b1;
    flush = 1'b0;
    set_if(32'h0, 7'h0, 5'd0, 5'd0);
    set_upd(1'b0, 32'h0, 7'h0, 5'd0, 5'd0, 32'h0);
  endtask

  task automatic step(input string name, input logic chk, input logic eh, input logic er,
                      input logic [31:0] et);
    exp_t e;
    if (chk) begin
      e.name = name; e.eh = eh; e.er = er; e.et = et;
      sb_q.push_back(e);
      chk_en = 1'b1;
    end
    @(posedge clk);
    #1;
    chk_en = 1'b0;
  endtask

  task automatic train(input logic [31:0] pc, input logic [6:0] op, input logic [31:0] tgt);
    set_upd(1'b1, pc, op, 5'd0, 5'd0, tgt);
    set_if(32'h0, 7'h0, 5'd0, 5'd0);
    step("train", 1'b0, 1'b0, 1'b0, 32'h0);
    set_upd(1'b0, 32'h0, 7'h0, 5'd0, 5'd0, 32'h0);
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic [6:0] op,
                      input logic eh, input logic [31:0] et);
    set_if(pc, op, 5'd0, 5'd0);
    step(name, 1'b1, eh, 1'b0, et);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;

    set_if(32'h100, JAL, 5'd0, 5'd0);
    step("reset_lookup", 1'b1, 1'b0, 1'b0, 32'h0);
    set_if(32'h10, JALR, 5'd0, 5'd1);
    step("reset_ret", 1'b1, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;

    // BTB fill and hit
    set_upd(1'b1, 32'h100, JAL, 5'd0, 5'd0, 32'h200);
    set_if(32'h100, JAL, 5'd0, 5'd0);
    step("same_cycle_miss", 1'b1, 1'b0, 1'b0, 32'h0);
    set_upd(1'b0, 32'h0, 7'h0, 5'd0, 5'd0, 32'h0);
    look("jal_hit_0x100", 32'h100, JAL, 1'b1, 32'h200);

    // Conflict and PLRU in set 0
    train(32'h180, JAL, 32'h380);
    train(32'h200, JAL, 32'h400);
    look("evicted_0x100", 32'h100, JAL, 1'b0, 32'h0);
    look("hit_0x180", 32'h180, BR, 1'b1, 32'h380);
    look("hit_0x200", 32'h200, JALR, 1'b1, 32'h400);
    train(32'h180, JAL, 32'h388);
    train(32'h280, BR, 32'h480);
    look("evicted_0x200", 32'h200, JAL, 1'b0, 32'h0);
    look("rewrite_0x180", 32'h180, JAL, 1'b1, 32'h388);
    look("hit_0x280", 32'h280, BR, 1'b1, 32'h480);

    // Returns are never written into the BTB
    set_upd(1'b1, 32'h2400, JALR, 5'd0, 5'd1, 32'h9990);
    step("train_ret", 1'b0, 1'b0, 1'b0, 32'h0);
    set_upd(1'b0, 32'h0, 7'h0, 5'd0, 5'd0, 32'h0);
    look("ret_not_trained", 32'h2400, JALR, 1'b0, 32'h0);

    // Call / return
    set_if(32'h400, JAL, 5'd1, 5'd0);
    step("call_0x400", 1'b1, 1'b0, 1'b0, 32'h0);
    set_if(32'h410, JALR, 5'd0, 5'd1);
    step("ret_0x404", 1'b1, 1'b1, 1'b1, 32'h404);
    step("ret_empty_fallback", 1'b1, 1'b0, 1'b0, 32'h0);

    // RAS overflow: nine calls, eight returns served, ninth finds it empty
    for (int k = 0; k < 9; k++) begin
      set_if(32'h1000 + 32'(16 * k), JAL, k[0] ? 5'd5 : 5'd1, 5'd0);
      step($sformatf("ovf_call_%0d", k), 1'b1, 1'b0, 1'b0, 32'h0);
    end
    for (int k = 0; k < 8; k++) begin
      set_if(32'h2000, JALR, 5'd0, k[0] ? 5'd5 : 5'd1);
      step($sformatf("ovf_ret_%0d", k), 1'b1, 1'b1, 1'b1, 32'h1084 - 32'(16 * k));
    end
    set_if(32'h2000, JALR, 5'd0, 5'd1);
    step("ovf_ret_empty", 1'b1, 1'b0, 1'b0, 32'h0);

    // Call+return replaces top of stack, count unchanged
    set_if(32'h3000, JAL, 5'd1, 5'd0);
    step("call_0x3000", 1'b1, 1'b0, 1'b0, 32'h0);
    set_if(32'h3100, JALR, 5'd5, 5'd1);
    step("callret_0x3100", 1'b1, 1'b0, 1'b0, 32'h0);
    set_if(32'h3110, JALR, 5'd0, 5'd5);
    step("ret_after_repl", 1'b1, 1'b1, 1'b1, 32'h3104);
    step("ret_after_repl_empty", 1'b1, 1'b0, 1'b0, 32'h0);

    // Flush repair
    set_if(32'h500, JAL, 5'd1, 5'd0);
    set_upd(1'b1, 32'h500, JAL, 5'd1, 5'd0, 32'h900);
    step("call_0x500", 1'b1, 1'b0, 1'b0, 32'h0);
    set_upd(1'b0, 32'h0, 7'h0, 5'd0, 5'd0, 32'h0);
    set_if(32'h600, JAL, 5'd1, 5'd0);
    step("spec_call_0x600", 1'b1, 1'b0, 1'b0, 32'h0);
    set_if(32'h700, JAL, 5'd5, 5'd0);
    step("spec_call_0x700", 1'b1, 1'b0, 1'b0, 32'h0);
    flush = 1'b1;
    set_if(32'h800, JAL, 5'd1, 5'd0);
    step("flush_cycle", 1'b1, 1'b0, 1'b0, 32'h0);
    flush = 1'b0;
    set_if(32'h710, JALR, 5'd0, 5'd1);
    step("ret_after_flush", 1'b1, 1'b1, 1'b1, 32'h504);
    step("ret_after_flush_empty", 1'b1, 1'b0, 1'b0, 32'h0);

    // Stall freezes everything, including flush and the committed RAS
    set_if(32'h3200, JAL, 5'd1, 5'd0);
    step("call_0x3200", 1'b1, 1'b0, 1'b0, 32'h0);
    load = 1'b0;
    flush = 1'b1;
    set_upd(1'b1, 32'h300, JAL, 5'd1, 5'd0, 32'h700);
    set_if(32'h300, JAL, 5'd1, 5'd0);
    step("stall_cycle", 1'b1, 1'b0, 1'b0, 32'h0);
    load = 1'b1;
    flush = 1'b0;
    set_upd(1'b0, 32'h0, 7'h0, 5'd0, 5'd0, 32'h0);
    look("stall_no_train", 32'h300, JAL, 1'b0, 32'h0);
    set_if(32'h3210, JALR, 5'd0, 5'd1);
    step("stall_ret", 1'b1, 1'b1, 1'b1, 32'h3204);
    flush = 1'b1;
    set_if(32'h0, 7'h0, 5'd0, 5'd0);
    step("flush_after_stall", 1'b1, 1'b0, 1'b0, 32'h0);
    flush = 1'b0;
    set_if(32'h3220, JALR, 5'd0, 5'd1);
    step("committed_frozen", 1'b1, 1'b1, 1'b1, 32'h504);

    // Asynchronous reset mid-run
    look("pre_reset_hit", 32'h500, JAL, 1'b1, 32'h900);
    set_if(32'h3300, JAL, 5'd1, 5'd0);
    step("call_0x3300", 1'b1, 1'b0, 1'b0, 32'h0);
    set_if(32'h3310, JALR, 5'd0, 5'd1);
    set_upd(1'b1, 32'h2800, JAL, 5'd0, 5'd0, 32'habc0);
    rst = 1'b1;
    step("reset_async", 1'b1, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    set_upd(1'b0, 32'h0, 7'h0, 5'd0, 5'd0, 32'h0);
    look("post_reset_miss", 32'h500, JAL, 1'b0, 32'h0);
    look("pending_upd_dropped", 32'h2800, JAL, 1'b0, 32'h0);
    set_if(32'h3310, JALR, 5'd0, 5'd1);
    step("post_reset_ret", 1'b1, 1'b0, 1'b0, 32'h0);
    train(32'h100, JAL, 32'h200);
    look("post_reset_retrain", 32'h100, JAL, 1'b1, 32'h200);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
